button_debouncer: RTL and testbench



---
 rtl/button_debouncer_if.sv | 29 ++
 rtl/button_debouncer.sv | 120 ++++++++++++
 tb/tb_button_debouncer.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/button_debouncer_if.sv
// ============================================================================
// Module   : button_debouncer_if
// Brief    : Raw button level in, debounced level and debug status out.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface button_debouncer_if;
  logic       btn_in;
  logic       btn_db;
  logic       busy;
  logic [7:0] glitch_cnt;

  modport master (
    output btn_in,
    input  btn_db,
    input  busy,
    input  glitch_cnt
  );

  modport slave (
    input  btn_in,
    output btn_db,
    output busy,
    output glitch_cnt
  );
endinterface

`default_nettype wire

// File: rtl/button_debouncer.sv
// ============================================================================
// Module   : button_debouncer
// Brief    : Synchronizes a bouncing button and qualifies each level change.
// Revision : 1.0
// ============================================================================
`default_nettype none

module button_debouncer #(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 4
) (
  input  wire logic          clk,
  input  wire logic          reset,
  button_debouncer_if.slave  bus
);

  localparam int c_CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(STABLE_CYCLES - 1);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

  localparam logic [1:0] c_IDLE_LO = 2'd0;
  localparam logic [1:0] c_CHK_HI  = 2'd1;
  localparam logic [1:0] c_IDLE_HI = 2'd2;
  localparam logic [1:0] c_CHK_LO  = 2'd3;

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_btn_s;
  logic [1:0]             r_state;
  logic [1:0]             w_state_nxt;
  logic [c_CNT_W-1:0]     r_cnt;
  logic [c_CNT_W-1:0]     w_cnt_nxt;
  logic                   w_abort;
  logic [7:0]             r_glitch_cnt;

  // Synchronizer: the only place btn_in is sampled.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], bus.btn_in};
    end
  end

  assign w_btn_s = r_sync[SYNC_STAGES-1];

  // State register, stability counter and saturating abort counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= c_IDLE_LO;
      r_cnt        <= '0;
      r_glitch_cnt <= 8'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_abort && (r_glitch_cnt != 8'hFF)) begin
        r_glitch_cnt <= r_glitch_cnt + 8'd1;
      end
    end
  end

  always_comb begin
    w_state_nxt = c_IDLE_LO;
    w_cnt_nxt   = '0;
    w_abort     = 1'b0;
    case (r_state)
      c_IDLE_LO: begin
        if (w_btn_s) begin
          w_state_nxt = c_CHK_HI;
          w_cnt_nxt   = c_CNT_ONE;
        end else begin
          w_state_nxt = c_IDLE_LO;
        end
      end
      c_CHK_HI: begin
        if (!w_btn_s) begin
          w_state_nxt = c_IDLE_LO;
          w_abort     = 1'b1;
        end else if (r_cnt == c_CNT_LAST) begin
          w_state_nxt = c_IDLE_HI;
        end else begin
          w_state_nxt = c_CHK_HI;
          w_cnt_nxt   = r_cnt + c_CNT_ONE;
        end
      end
      c_IDLE_HI: begin
        if (!w_btn_s) begin
          w_state_nxt = c_CHK_LO;
          w_cnt_nxt   = c_CNT_ONE;
        end else begin
          w_state_nxt = c_IDLE_HI;
        end
      end
      c_CHK_LO: begin
        if (w_btn_s) begin
          w_state_nxt = c_IDLE_HI;
          w_abort     = 1'b1;
        end else if (r_cnt == c_CNT_LAST) begin
          w_state_nxt = c_IDLE_LO;
        end else begin
          w_state_nxt = c_CHK_LO;
          w_cnt_nxt   = r_cnt + c_CNT_ONE;
        end
      end
      default: begin
        w_state_nxt = c_IDLE_LO;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Moore outputs decoded from the registered state only.
  always_comb begin
    bus.btn_db     = (r_state == c_IDLE_HI) || (r_state == c_CHK_LO);
    bus.busy       = (r_state == c_CHK_HI)  || (r_state == c_CHK_LO);
    bus.glitch_cnt = r_glitch_cnt;
  end

endmodule

`default_nettype wire

// File: tb/tb_button_debouncer.sv
// ============================================================================
// Module   : tb_button_debouncer
// Brief    : Directed self-checking bench for button_debouncer (defaults).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_button_debouncer;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   rise_cnt = 0;
  logic db_q = 1'b0;

  button_debouncer_if bus ();

  button_debouncer #(
    .SYNC_STAGES   (2),
    .STABLE_CYCLES (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Stand-in for the downstream rising-edge pulse generator.
  always @(posedge clk) begin
    db_q <= bus.btn_db;
    if (bus.btn_db && !db_q) rise_cnt <= rise_cnt + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    bus.btn_in = 1'b0;
    do_reset();
    checks++;
    if (bus.btn_db !== 1'b0) begin errors++; $display("FAIL reset_db got %b exp 0", bus.btn_db); end
    checks++;
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", bus.busy); end
    checks++;
    if (bus.glitch_cnt !== 8'd0) begin errors++; $display("FAIL reset_glitch got %0d exp 0", bus.glitch_cnt); end
  endtask

  task automatic test_clean_press();
    bus.btn_in = 1'b0;
    do_reset();
    bus.btn_in = 1'b1;
    tick(2);
    checks++;
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL press_busy_e2 got %b exp 0", bus.busy); end
    tick(1);
    checks++;
    if (bus.busy !== 1'b1) begin errors++; $display("FAIL press_busy_e3 got %b exp 1", bus.busy); end
    tick(2);
    checks++;
    if (bus.btn_db !== 1'b0) begin errors++; $display("FAIL press_db_e5 got %b exp 0", bus.btn_db); end
    tick(1);
    checks++;
    if (bus.btn_db !== 1'b1) begin errors++; $display("FAIL press_db_e6 got %b exp 1", bus.btn_db); end
    checks++;
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL press_busy_e6 got %b exp 0", bus.busy); end
    checks++;
    if (bus.glitch_cnt !== 8'd0) begin errors++; $display("FAIL press_glitch got %0d exp 0", bus.glitch_cnt); end
  endtask

  task automatic test_short_glitch();
    bus.btn_in = 1'b0;
    do_reset();
    bus.btn_in = 1'b1;
    tick(2);
    bus.btn_in = 1'b0;
    tick(1);
    checks++;
    if (bus.busy !== 1'b1) begin errors++; $display("FAIL glitch_busy_e3 got %b exp 1", bus.busy); end
    tick(1);
    checks++;
    if (bus.busy !== 1'b1) begin errors++; $display("FAIL glitch_busy_e4 got %b exp 1", bus.busy); end
    tick(1);
    checks++;
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL glitch_busy_e5 got %b exp 0", bus.busy); end
    checks++;
    if (bus.glitch_cnt !== 8'd1) begin errors++; $display("FAIL glitch_cnt got %0d exp 1", bus.glitch_cnt); end
    tick(4);
    checks++;
    if (bus.btn_db !== 1'b0) begin errors++; $display("FAIL glitch_db got %b exp 0", bus.btn_db); end
  endtask

  task automatic test_bounce();
    logic [5:0] pat;
    int r0;
    pat = 6'b101101;   // applied MSB first: 1,0,1,1,0,1
    bus.btn_in = 1'b0;
    do_reset();
    tick(1);
    r0 = rise_cnt;
    for (int k = 5; k >= 0; k--) begin
      bus.btn_in = pat[k];
      tick(1);
    end
    bus.btn_in = 1'b1;
    tick(4);
    checks++;
    if (bus.btn_db !== 1'b0) begin errors++; $display("FAIL bounce_db_early got %b exp 0", bus.btn_db); end
    tick(1);
    checks++;
    if (bus.btn_db !== 1'b1) begin errors++; $display("FAIL bounce_db_rise got %b exp 1", bus.btn_db); end
    checks++;
    if (bus.glitch_cnt !== 8'd2) begin errors++; $display("FAIL bounce_glitch got %0d exp 2", bus.glitch_cnt); end
    tick(3);
    checks++;
    if (rise_cnt - r0 !== 1) begin errors++; $display("FAIL bounce_pulses got %0d exp 1", rise_cnt - r0); end
  endtask

  // Continues from IDLE_HI with glitch_cnt == 2 left by test_bounce.
  task automatic test_release();
    bus.btn_in = 1'b0;
    tick(3);
    bus.btn_in = 1'b1;
    tick(8);
    checks++;
    if (bus.btn_db !== 1'b1) begin errors++; $display("FAIL release_glitch_db got %b exp 1", bus.btn_db); end
    checks++;
    if (bus.glitch_cnt !== 8'd3) begin errors++; $display("FAIL release_glitch_cnt got %0d exp 3", bus.glitch_cnt); end
    bus.btn_in = 1'b0;
    tick(5);
    checks++;
    if (bus.btn_db !== 1'b1) begin errors++; $display("FAIL release_db_e5 got %b exp 1", bus.btn_db); end
    tick(1);
    checks++;
    if (bus.btn_db !== 1'b0) begin errors++; $display("FAIL release_db_e6 got %b exp 0", bus.btn_db); end
    checks++;
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL release_busy got %b exp 0", bus.busy); end
  endtask

  task automatic test_reset_mid_check();
    bus.btn_in = 1'b0;
    do_reset();
    bus.btn_in = 1'b1;
    tick(2);
    bus.btn_in = 1'b0;
    tick(6);
    bus.btn_in = 1'b1;
    tick(4);
    checks++;
    if (bus.busy !== 1'b1 || bus.glitch_cnt !== 8'd1) begin
      errors++;
      $display("FAIL midrst_pre got busy=%b glitch=%0d exp busy=1 glitch=1", bus.busy, bus.glitch_cnt);
    end
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    checks++;
    if (bus.btn_db !== 1'b0 || bus.busy !== 1'b0 || bus.glitch_cnt !== 8'd0) begin
      errors++;
      $display("FAIL midrst_post got db=%b busy=%b glitch=%0d exp 0/0/0", bus.btn_db, bus.busy, bus.glitch_cnt);
    end
    tick(5);
    checks++;
    if (bus.btn_db !== 1'b0) begin errors++; $display("FAIL midrst_db_e5 got %b exp 0", bus.btn_db); end
    tick(1);
    checks++;
    if (bus.btn_db !== 1'b1) begin errors++; $display("FAIL midrst_db_e6 got %b exp 1", bus.btn_db); end
  endtask

  task automatic test_saturation();
    logic saw_db;
    saw_db = 1'b0;
    bus.btn_in = 1'b0;
    do_reset();
    for (int i = 1; i <= 300; i++) begin
      bus.btn_in = 1'b1;
      for (int c = 0; c < 6; c++) begin
        if (c == 2) bus.btn_in = 1'b0;
        tick(1);
        if (bus.btn_db !== 1'b0) saw_db = 1'b1;
      end
      if (i == 100) begin
        checks++;
        if (bus.glitch_cnt !== 8'd100) begin errors++; $display("FAIL sat_cnt100 got %0d exp 100", bus.glitch_cnt); end
      end
      if (i == 255) begin
        checks++;
        if (bus.glitch_cnt !== 8'd255) begin errors++; $display("FAIL sat_cnt255 got %0d exp 255", bus.glitch_cnt); end
      end
    end
    checks++;
    if (bus.glitch_cnt !== 8'd255) begin errors++; $display("FAIL sat_hold got %0d exp 255", bus.glitch_cnt); end
    checks++;
    if (saw_db !== 1'b0) begin errors++; $display("FAIL sat_db got %b exp 0", saw_db); end
  endtask

  initial begin
    bus.btn_in = 1'b0;
    test_reset();
    test_clean_press();
    test_short_glitch();
    test_bounce();
    test_release();
    test_reset_mid_check();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
